mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single virtual memory port (address / write data / write enable / read data) between the instruction-fetch requester and the load/store requester.
- Sits between the CPU core and the memory controller.
- Registers each transaction, waits a fixed memory latency, captures the read data and returns a one-cycle acknowledge to the winning requester.
- Round-robin tie-break, so neither requester can starve.

Parameters:
- MEM_LATENCY, 1: cycles an access is held on the virtual port before read data is sampled; legal range 1..255.
- RESET_LAST_GRANT, 0: value of the last-grant register at reset (0 = instruction, 1 = data). Default 0 makes data win the first tie.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- reqI  in  1  instruction-fetch request; held high until ackI
- addressI  in  32  fetch virtual address
- ackI  out  1  one-cycle pulse: fetch complete, dataOutI valid
- dataOutI  out  32  fetched word; held until next ackI
- reqD  in  1  load/store request; held high until ackD
- addressD  in  32  load/store virtual address
- dataInD  in  32  store data
- wEnD  in  1  1 = store, 0 = load
- ackD  out  1  one-cycle pulse: load/store complete, dataOutD valid on loads
- dataOutD  out  32  loaded word; held until next ackD
- addressVirt  out  32  address to memory controller
- dataInVirt  out  32  write data to memory controller
- wEnVirt  out  1  write enable to memory controller
- dataOutVirt  in  32  read data from memory controller
- busy  out  1  high while state is ACCESS

Behaviour:
- Reset (async, any time, including mid-ACCESS): state = IDLE, counter = 0, lastGrant = RESET_LAST_GRANT. All outputs 0: ackI, ackD, dataOutI, dataOutD, addressVirt, dataInVirt, wEnVirt, busy. An in-flight transaction is dropped with no ack.
- State IDLE:
  - Virtual port outputs are 0.
  - An effective request is req masked by the same-cycle ack of that port. A requester seeing its ack must not be re-granted in that cycle; if its req is still high on the next cycle it counts as a new request.
  - Only I requests: grant I. Only D requests: grant D. Both: grant the port opposite lastGrant.
  - On grant, latch address, and for D also dataInD and wEnD (I always latches wEn = 0). Then set lastGrant, load counter = MEM_LATENCY, go to ACCESS.
  - No effective request: stay in IDLE.
- State ACCESS:
  - addressVirt and dataInVirt are driven from the latched registers for all MEM_LATENCY cycles.
  - wEnVirt = latched wEn only in the first ACCESS cycle, so a store writes exactly once. It is 0 in all later cycles.
  - Counter decrements each cycle.
  - In the last ACCESS cycle (counter = 1), sample dataOutVirt into the granted port's dataOut register (stores also sample it; the value is don't-care). Assert that port's ack registered for the next cycle, then go to IDLE.
  - Requester inputs and req changes during ACCESS are ignored.
- Timing: request first seen in IDLE at cycle t; ACCESS occupies cycles t+1 .. t+MEM_LATENCY; ack is high in cycle t+MEM_LATENCY+1 (state IDLE). The ack cycle can grant the other requester, so back-to-back throughput is one transaction per MEM_LATENCY+1 cycles.
- ackI and ackD are never high together. Each is high for exactly one cycle per transaction.
- dataOutI and dataOutD change only on their own completion.
- busy = (state == ACCESS).
- Counter is 8 bits; MEM_LATENCY = 0 is illegal and is rejected by an elaboration-time check.
- Requesters violating hold-until-ack get undefined results for that transaction. The arbiter itself never deadlocks.

Test Plan:
- Reset, then reqI=1, addressI=0x0000_0010, MEM_LATENCY=1, memory returns 0xDEAD_BEEF -> addressVirt=0x10 in cycle 1; ackI=1 and dataOutI=0xDEAD_BEEF in cycle 2; wEnVirt stays 0 throughout.
- reqD=1, wEnD=1, addressD=0x1000_0004, dataInD=0x1234_5678, MEM_LATENCY=3 -> wEnVirt=1 only in the first of three ACCESS cycles, dataInVirt=0x1234_5678 for all three, ackD pulses once in cycle 4.
- reqI and reqD held high continuously from reset -> grants go D, I, D, I; acks alternate; no port gets two consecutive grants; every ack lasts one cycle.
- reqD held high through its ack with a new addressD=0x1000_0008, reqI low -> no grant in the ack cycle; a new D grant in the following cycle with the new address latched.
- Assert rst in the second ACCESS cycle of a MEM_LATENCY=3 store -> all outputs 0 immediately (asynchronously), no ackD; after release with no requests, state stays IDLE and busy=0.
- Change addressI from 0x20 to 0x40 mid-ACCESS -> addressVirt stays 0x20 until the transaction completes.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one virtual memory port between instruction fetch
// and load/store. Each access is held for MEM_LATENCY cycles, then acknowledged.
module mem_port_arbiter #(
    parameter int MEM_LATENCY      = 1,
    parameter bit RESET_LAST_GRANT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqI,
    input  logic [31:0] addressI,
    output logic        ackI,
    output logic [31:0] dataOutI,
    input  logic        reqD,
    input  logic [31:0] addressD,
    input  logic [31:0] dataInD,
    input  logic        wEnD,
    output logic        ackD,
    output logic [31:0] dataOutD,
    output logic [31:0] addressVirt,
    output logic [31:0] dataInVirt,
    output logic        wEnVirt,
    input  logic [31:0] dataOutVirt,
    output logic        busy
);

    localparam logic [7:0] LAT = 8'(MEM_LATENCY);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 255) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be in 1..255");
    end

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, state_next;
    logic [7:0]  count;
    logic        last_grant;
    logic        grant_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wen_q;

    // A port whose ack is high this cycle cannot be re-granted in the same cycle.
    logic eff_i, eff_d, start, pick_d, done;
    assign eff_i  = reqI & ~ackI;
    assign eff_d  = reqD & ~ackD;
    assign start  = eff_i | eff_d;
    assign pick_d = eff_d & (~eff_i | ~last_grant);
    assign done   = (count == 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCESS;
            ACCESS:  if (done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 8'd0;
            last_grant <= RESET_LAST_GRANT;
            grant_d    <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wen_q      <= 1'b0;
            ackI       <= 1'b0;
            ackD       <= 1'b0;
            dataOutI   <= 32'd0;
            dataOutD   <= 32'd0;
        end else begin
            ackI <= 1'b0;
            ackD <= 1'b0;
            if (state == IDLE && start) begin
                grant_d    <= pick_d;
                last_grant <= pick_d;
                addr_q     <= pick_d ? addressD : addressI;
                wdata_q    <= pick_d ? dataInD : 32'd0;
                wen_q      <= pick_d & wEnD;
                count      <= LAT;
            end else if (state == ACCESS) begin
                count <= count - 8'd1;
                if (done) begin
                    if (grant_d) begin
                        dataOutD <= dataOutVirt;
                        ackD     <= 1'b1;
                    end else begin
                        dataOutI <= dataOutVirt;
                        ackI     <= 1'b1;
                    end
                end
            end
        end
    end

    // The write strobe is limited to the first access cycle so a store lands once.
    assign busy        = (state == ACCESS);
    assign addressVirt = busy ? addr_q  : 32'd0;
    assign dataInVirt  = busy ? wdata_q : 32'd0;
    assign wEnVirt     = busy & wen_q & (count == LAT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios on latency-1 and latency-3
// instances, then randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // latency-3 instance
    logic        reqI, reqD, wEnD, ackI, ackD, wEnVirt, busy;
    logic [31:0] addressI, addressD, dataInD, dataOutI, dataOutD;
    logic [31:0] addressVirt, dataInVirt, dataOutVirt;

    // latency-1 instance
    logic        l1_reqI, l1_ackI, l1_ackD, l1_wEnVirt, l1_busy;
    logic [31:0] l1_addressI, l1_dataOutI, l1_dataOutD;
    logic [31:0] l1_addressVirt, l1_dataInVirt, l1_rdata;
    logic        l1_zero_bit;
    logic [31:0] l1_zero_word;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign dataOutVirt = mem_word(addressVirt);

    mem_port_arbiter #(.MEM_LATENCY(LAT), .RESET_LAST_GRANT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .reqI(reqI), .addressI(addressI), .ackI(ackI), .dataOutI(dataOutI),
        .reqD(reqD), .addressD(addressD), .dataInD(dataInD), .wEnD(wEnD),
        .ackD(ackD), .dataOutD(dataOutD),
        .addressVirt(addressVirt), .dataInVirt(dataInVirt), .wEnVirt(wEnVirt),
        .dataOutVirt(dataOutVirt), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .RESET_LAST_GRANT(1'b0)) dut_l1 (
        .clk(clk), .rst(rst),
        .reqI(l1_reqI), .addressI(l1_addressI), .ackI(l1_ackI), .dataOutI(l1_dataOutI),
        .reqD(l1_zero_bit), .addressD(l1_zero_word), .dataInD(l1_zero_word), .wEnD(l1_zero_bit),
        .ackD(l1_ackD), .dataOutD(l1_dataOutD),
        .addressVirt(l1_addressVirt), .dataInVirt(l1_dataInVirt), .wEnVirt(l1_wEnVirt),
        .dataOutVirt(l1_rdata), .busy(l1_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reqI = 1'b0; addressI = 32'd0;
        reqD = 1'b0; addressD = 32'd0; dataInD = 32'd0; wEnD = 1'b0;
        l1_reqI = 1'b0; l1_addressI = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ctl"}, {28'd0, ackI, ackD, wEnVirt, busy}, 32'd0);
        chk({tag, ".dout_i"}, dataOutI, 32'd0);
        chk({tag, ".dout_d"}, dataOutD, 32'd0);
        chk({tag, ".addr_v"}, addressVirt, 32'd0);
        chk({tag, ".wdata_v"}, dataInVirt, 32'd0);
    endtask

    // reference model state for the randomized phase
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    int          g_at, ack_at, free_at;
    bit          g_d, g_w, m_last, ack_d, e_ack_i, e_ack_d, e_busy, eff_i, eff_d, win_d;
    logic [31:0] g_addr, g_wdata, cur_i, cur_d;

    initial begin
        clear_inputs();
        l1_zero_bit  = 1'b0;
        l1_zero_word = 32'd0;
        l1_rdata     = 32'hDEAD_BEEF;
        rst = 1'b1;
        step();
        chk_all_zero("reset");
        chk("reset.l1", {l1_ackI, l1_busy, l1_wEnVirt, l1_dataOutI}, 35'd0);
        rst = 1'b0;

        // latency 1 fetch
        l1_reqI = 1'b1; l1_addressI = 32'h0000_0010;
        chk("l1.c0.wen", {31'd0, l1_wEnVirt}, 32'd0);
        step();
        chk("l1.c1.addr", l1_addressVirt, 32'h0000_0010);
        chk("l1.c1.busy_wen", {30'd0, l1_busy, l1_wEnVirt}, 32'd2);
        step();
        chk("l1.c2.ack", {30'd0, l1_ackI, l1_busy}, 32'd2);
        chk("l1.c2.data", l1_dataOutI, 32'hDEAD_BEEF);
        chk("l1.c2.wen", {31'd0, l1_wEnVirt}, 32'd0);
        l1_reqI = 1'b0;
        step();
        chk("l1.c3.ack", {31'd0, l1_ackI}, 32'd0);

        // latency 3 store
        reqD = 1'b1; wEnD = 1'b1; addressD = 32'h1000_0004; dataInD = 32'h1234_5678;
        for (int k = 1; k <= LAT; k++) begin
            step();
            chk("st.busy", {31'd0, busy}, 32'd1);
            chk("st.wen", {31'd0, wEnVirt}, (k == 1) ? 32'd1 : 32'd0);
            chk("st.wdata", dataInVirt, 32'h1234_5678);
            chk("st.addr", addressVirt, 32'h1000_0004);
            chk("st.noack", {31'd0, ackD}, 32'd0);
        end
        step();
        chk("st.ack", {29'd0, ackD, ackI, wEnVirt}, 32'd4);
        chk("st.dout", dataOutD, mem_word(32'h1000_0004));
        reqD = 1'b0; wEnD = 1'b0;
        step();
        chk("st.ack_once", {31'd0, ackD}, 32'd0);

        // both requesting continuously from reset: D, I, D, I
        do_reset();
        reqI = 1'b1; addressI = $urandom;
        reqD = 1'b1; addressD = $urandom;
        for (int c = 1; c <= 4 * (LAT + 1); c++) begin
            step();
            chk("rr.ackD", {31'd0, ackD}, (c % 8 == 4) ? 32'd1 : 32'd0);
            chk("rr.ackI", {31'd0, ackI}, (c % 8 == 0) ? 32'd1 : 32'd0);
            chk("rr.busy", {31'd0, busy}, (c % 4 != 0) ? 32'd1 : 32'd0);
            if (c % 4 != 0)
                chk("rr.addr", addressVirt, ((c / 4) % 2 == 0) ? addressD : addressI);
            if (c % 8 == 4) chk("rr.doutD", dataOutD, mem_word(addressD));
            if (c % 8 == 0) chk("rr.doutI", dataOutI, mem_word(addressI));
        end
        reqI = 1'b0; reqD = 1'b0;
        step();
        chk("rr.idle", {31'd0, busy}, 32'd0);

        // D held through its ack with a new address
        reqD = 1'b1; addressD = 32'h1000_0000;
        repeat (LAT + 1) step();
        chk("hold.ack1", {31'd0, ackD}, 32'd1);
        chk("hold.dout1", dataOutD, mem_word(32'h1000_0000));
        addressD = 32'h1000_0008;
        step();
        chk("hold.nogrant", {30'd0, busy, ackD}, 32'd0);
        step();
        chk("hold.regrant", {31'd0, busy}, 32'd1);
        chk("hold.addr", addressVirt, 32'h1000_0008);
        repeat (LAT) step();
        chk("hold.ack2", {31'd0, ackD}, 32'd1);
        chk("hold.dout2", dataOutD, mem_word(32'h1000_0008));
        reqD = 1'b0;

        // reset during the second access cycle of a store
        step();
        reqD = 1'b1; wEnD = 1'b1; addressD = 32'h2000_0000; dataInD = 32'hCAFE_F00D;
        step();
        step();
        chk("rst_mid.busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        reqD = 1'b0; wEnD = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 2 * (LAT + 1); k++) begin
            step();
            chk("rst_mid.idle", {30'd0, busy, ackD}, 32'd0);
        end

        // fetch address changing mid-access is ignored
        reqI = 1'b1; addressI = 32'h0000_0020;
        step();
        chk("mid.addr1", addressVirt, 32'h0000_0020);
        addressI = 32'h0000_0040;
        repeat (LAT - 1) begin
            step();
            chk("mid.addr", addressVirt, 32'h0000_0020);
        end
        step();
        chk("mid.ack", {31'd0, ackI}, 32'd1);
        chk("mid.dout", dataOutI, mem_word(32'h0000_0020));
        reqI = 1'b0;

        // randomized traffic against the transaction model
        clear_inputs();
        do_reset();
        g_at = -100; ack_at = -1; free_at = 0; m_last = 1'b0; ack_d = 1'b0;
        g_d = 1'b0; g_w = 1'b0; g_addr = 32'd0; g_wdata = 32'd0;
        cur_i = 32'd0; cur_d = 32'd0;
        for (int c = 1; c <= 800; c++) begin
            step();
            e_ack_i = (ack_at == c) && !ack_d;
            e_ack_d = (ack_at == c) && ack_d;
            e_busy  = (c > g_at) && (c <= g_at + LAT);
            if (e_ack_i && exp_i_q.size() > 0) cur_i = exp_i_q.pop_front();
            if (e_ack_d && exp_d_q.size() > 0) cur_d = exp_d_q.pop_front();
            chk("rnd.acks", {30'd0, ackI, ackD}, {30'd0, e_ack_i, e_ack_d});
            chk("rnd.busy", {31'd0, busy}, {31'd0, e_busy});
            chk("rnd.addr", addressVirt, e_busy ? g_addr : 32'd0);
            chk("rnd.wdata", dataInVirt, e_busy ? g_wdata : 32'd0);
            chk("rnd.wen", {31'd0, wEnVirt}, {31'd0, g_w && (c == g_at + 1)});
            chk("rnd.doutI", dataOutI, cur_i);
            chk("rnd.doutD", dataOutD, cur_d);

            if (!reqI || e_ack_i) begin
                reqI = ($urandom_range(0, 2) == 0);
                addressI = $urandom;
            end
            if (!reqD || e_ack_d) begin
                reqD = ($urandom_range(0, 2) == 0);
                addressD = $urandom;
                dataInD = $urandom;
                wEnD = $urandom_range(0, 1);
            end

            eff_i = reqI && !e_ack_i;
            eff_d = reqD && !e_ack_d;
            if (c >= free_at && (eff_i || eff_d)) begin
                win_d   = eff_d && (!eff_i || !m_last);
                m_last  = win_d;
                g_at    = c;
                g_d     = win_d;
                g_addr  = win_d ? addressD : addressI;
                g_wdata = win_d ? dataInD : 32'd0;
                g_w     = win_d && wEnD;
                ack_at  = c + LAT + 1;
                ack_d   = win_d;
                free_at = c + LAT + 1;
                if (win_d) exp_d_q.push_back(mem_word(g_addr));
                else       exp_i_q.push_back(mem_word(g_addr));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
